vdp99_cpu_port: RTL

VDP99_CPU_PORT -- requirements
Module: vdp99_cpu_port

---
 rtl/vdp99_cpu_port.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/vdp99_cpu_port.sv
// vdp99_cpu_port: CPU-side port of a TMS9918-style video processor.
// Decodes control-port byte pairs into register writes or VRAM address
// setup, and turns data-port accesses into a one-deep-queued VRAM
// request stream with a read-ahead buffer.
// Optional feature: define VDP99_WRITE_READAHEAD_EN to have data writes
// also update the read-ahead buffer.
module vdp99_cpu_port (
  input  logic        phi,
  input  logic        reset_n,
  input  logic        cpu_mode,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_dout,
  output logic        reg_we,
  output logic [2:0]  reg_num,
  output logic [7:0]  reg_data,
  output logic        vram_req,
  output logic        vram_we,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  input  logic        vram_ack,
  input  logic [7:0]  vram_rdata,
  input  logic [7:0]  status_in,
  output logic        status_clr
);

  typedef enum logic {FIRST = 1'b0, SECOND = 1'b1} tog_t;

  tog_t        tog_q, tog_d;
  logic        wr_q, wr_q2, rd_q, rd_q2;
  logic        rd_act_q, rd_mode_q;
  logic [7:0]  tmp_q, tmp_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  rab_q, rab_d;
  logic        reg_we_q, reg_we_d;
  logic [2:0]  reg_num_q, reg_num_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic        clr_q, clr_d;
  logic        req_q, we_q;
  logic [13:0] vaddr_q;
  logic [7:0]  vwdata_q;
  logic        pend_v_q, pend_we_q;
  logic [13:0] pend_addr_q;
  logic [7:0]  pend_wdata_q;
  logic        wr_start, rd_start, rd_end;
  logic        new_v, new_we;
  logic [13:0] new_addr;
  logic [13:0] setup_addr;

  assign setup_addr = {cpu_din[5:0], tmp_q};

  // Bus-cycle decode and next-state for toggle, address, buffers, pulses
  always_comb begin
    wr_start   = wr_q & ~wr_q2;
    // a read starting together with a write is dropped entirely
    rd_start   = rd_q & ~rd_q2 & ~wr_start;
    rd_end     = rd_q2 & ~rd_q & rd_act_q;
    tog_d      = tog_q;
    tmp_d      = tmp_q;
    addr_d     = addr_q;
    rab_d      = rab_q;
    reg_we_d   = 1'b0;
    reg_num_d  = reg_num_q;
    reg_data_d = reg_data_q;
    clr_d      = 1'b0;
    new_v      = 1'b0;
    new_we     = 1'b0;
    new_addr   = addr_q;
    if (req_q && vram_ack && !we_q) rab_d = vram_rdata;
    if (wr_start) begin
      if (cpu_mode) begin
        if (tog_q == FIRST) begin
          tmp_d = cpu_din;
          tog_d = SECOND;
        end else begin
          tog_d = FIRST;
          if (cpu_din[7]) begin
            reg_we_d   = 1'b1;
            reg_num_d  = cpu_din[2:0];
            reg_data_d = tmp_q;
          end else if (cpu_din[6]) begin
            addr_d = setup_addr;
          end else begin
            // read-ahead fetches the set address and steps past it, so the
            // following data read refills from the next location
            new_v    = 1'b1;
            new_addr = setup_addr;
            addr_d   = setup_addr + 14'd1;
          end
        end
      end else begin
        tog_d  = FIRST;
        new_v  = 1'b1;
        new_we = 1'b1;
        addr_d = addr_q + 14'd1;
`ifdef VDP99_WRITE_READAHEAD_EN
        rab_d  = cpu_din;
`endif
      end
    end else begin
      if (rd_start) tog_d = FIRST;
      if (rd_end) begin
        if (rd_mode_q) begin
          clr_d = 1'b1;
        end else begin
          new_v  = 1'b1;
          addr_d = addr_q + 14'd1;
        end
      end
    end
  end

  // State registers plus the outstanding/queued VRAM request slots
  always_ff @(posedge phi) begin
    if (!reset_n) begin
      tog_q        <= FIRST;
      wr_q         <= 1'b0;
      wr_q2        <= 1'b0;
      rd_q         <= 1'b0;
      rd_q2        <= 1'b0;
      rd_act_q     <= 1'b0;
      rd_mode_q    <= 1'b0;
      tmp_q        <= '0;
      addr_q       <= '0;
      rab_q        <= '0;
      reg_we_q     <= 1'b0;
      reg_num_q    <= '0;
      reg_data_q   <= '0;
      clr_q        <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      vaddr_q      <= '0;
      vwdata_q     <= '0;
      pend_v_q     <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
    end else begin
      wr_q       <= cpu_wr;
      wr_q2      <= wr_q;
      rd_q       <= cpu_rd;
      rd_q2      <= rd_q;
      if (rd_start) begin
        rd_act_q  <= 1'b1;
        rd_mode_q <= cpu_mode;
      end else if (rd_end) begin
        rd_act_q  <= 1'b0;
      end
      tog_q      <= tog_d;
      tmp_q      <= tmp_d;
      addr_q     <= addr_d;
      rab_q      <= rab_d;
      reg_we_q   <= reg_we_d;
      reg_num_q  <= reg_num_d;
      reg_data_q <= reg_data_d;
      clr_q      <= clr_d;
      if (req_q && vram_ack) req_q <= 1'b0;
      if (!req_q) begin
        if (pend_v_q) begin
          req_q    <= 1'b1;
          we_q     <= pend_we_q;
          vaddr_q  <= pend_addr_q;
          vwdata_q <= pend_wdata_q;
          pend_v_q <= new_v;
          if (new_v) begin
            pend_we_q    <= new_we;
            pend_addr_q  <= new_addr;
            pend_wdata_q <= cpu_din;
          end
        end else if (new_v) begin
          req_q    <= 1'b1;
          we_q     <= new_we;
          vaddr_q  <= new_addr;
          vwdata_q <= cpu_din;
        end
      end else if (new_v) begin
        // queued slot is overwritten when already full
        pend_v_q     <= 1'b1;
        pend_we_q    <= new_we;
        pend_addr_q  <= new_addr;
        pend_wdata_q <= cpu_din;
      end
    end
  end

  assign cpu_dout   = cpu_rd ? (cpu_mode ? status_in : rab_q) : '0;
  assign reg_we     = reg_we_q;
  assign reg_num    = reg_num_q;
  assign reg_data   = reg_data_q;
  assign status_clr = clr_q;
  assign vram_req   = req_q;
  assign vram_we    = we_q;
  assign vram_addr  = vaddr_q;
  assign vram_wdata = vwdata_q;

endmodule
